// File: rtl/qam16_frame_scheduler.sv
// qam16_frame_scheduler: turns payload bytes into preamble / sync / payload / gap frames
// of 4-bit QAM16 symbols on a single-register AXI-Stream master.
module qam16_frame_scheduler #(
    parameter int          PREAMBLE_LEN  = 8,
    parameter logic [15:0] SYNC_WORD     = 16'hD391,
    parameter int          PAYLOAD_BYTES = 16,
    parameter int          GAP_CYCLES    = 16
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic        enable,
    input  logic        err_clear,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [3:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        length_error
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, PAY_HI, PAY_LO, GAP} state_t;
    localparam logic [7:0]  PRE_N    = 8'(PREAMBLE_LEN);
    localparam logic [11:0] PAY_N    = 12'(PAYLOAD_BYTES);
    localparam logic [15:0] GAP_LAST = GAP_CYCLES > 0 ? 16'(GAP_CYCLES - 1) : 16'd0;
    state_t      state;
    logic [7:0]  sym_cnt;
    logic [11:0] byte_cnt;
    logic [15:0] gap_cnt;
    logic [3:0]  lo_nib;
    logic        last_byte;
    logic        lo_sent;
    logic        out_free;
    logic        xfer;
    logic        accept;
    logic        early_last;
    logic [11:0] byte_next;
    logic [3:0]  sync_nib;
    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign xfer          = m_axis_tvalid && m_axis_tready;
    assign s_axis_tready = (state == PAY_HI) && out_free;
    assign accept        = s_axis_tready && s_axis_tvalid;
    assign byte_next     = byte_cnt + 12'd1;
    assign early_last    = accept && s_axis_tlast && (byte_next != PAY_N);
    assign busy          = state != IDLE;
    // sym_cnt holds how many sync nibbles are already loaded
    assign sync_nib = sym_cnt[1:0] == 2'd1 ? SYNC_WORD[11:8] :
                      sym_cnt[1:0] == 2'd2 ? SYNC_WORD[7:4]  : SYNC_WORD[3:0];
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            m_axis_tdata  <= 4'h0;
            m_axis_tvalid <= 1'b0;
            frame_done    <= 1'b0;
            frame_count   <= 16'd0;
            length_error  <= 1'b0;
            sym_cnt       <= 8'd0;
            byte_cnt      <= 12'd0;
            gap_cnt       <= 16'd0;
            lo_nib        <= 4'h0;
            last_byte     <= 1'b0;
            lo_sent       <= 1'b0;
        end else begin
            frame_done   <= 1'b0;
            length_error <= early_last || (length_error && !err_clear);
            case (state)
                IDLE: if (enable && s_axis_tvalid) begin
                    state         <= PREAMBLE;
                    m_axis_tdata  <= 4'h0;
                    m_axis_tvalid <= 1'b1;
                    sym_cnt       <= 8'd1;
                    byte_cnt      <= 12'd0;
                    lo_sent       <= 1'b0;
                end
                PREAMBLE: if (xfer) begin
                    if (sym_cnt == PRE_N) begin
                        m_axis_tdata <= SYNC_WORD[15:12];
                        sym_cnt      <= 8'd1;
                        state        <= SYNC;
                    end else begin
                        m_axis_tdata <= {4{sym_cnt[0]}};
                        sym_cnt      <= sym_cnt + 8'd1;
                    end
                end
                // the last sync nibble is still in the output register when PAY_HI
                // begins, so the first payload nibble can follow it back-to-back
                SYNC: if (xfer) begin
                    m_axis_tdata <= sync_nib;
                    sym_cnt      <= sym_cnt + 8'd1;
                    if (sym_cnt[1:0] == 2'd3) state <= PAY_HI;
                end
                PAY_HI: begin
                    if (accept) begin
                        m_axis_tdata  <= s_axis_tdata[7:4];
                        m_axis_tvalid <= 1'b1;
                        lo_nib        <= s_axis_tdata[3:0];
                        byte_cnt      <= byte_next;
                        last_byte     <= s_axis_tlast || (byte_next == PAY_N);
                        state         <= PAY_LO;
                    end else if (out_free) m_axis_tvalid <= 1'b0;
                end
                PAY_LO: begin
                    if (lo_sent) begin
                        if (xfer) begin
                            m_axis_tvalid <= 1'b0;
                            frame_done    <= 1'b1;
                            frame_count   <= frame_count + 16'd1;
                            gap_cnt       <= 16'd0;
                            byte_cnt      <= 12'd0;
                            lo_sent       <= 1'b0;
                            state         <= GAP;
                        end
                    end else if (out_free) begin
                        m_axis_tdata  <= lo_nib;
                        m_axis_tvalid <= 1'b1;
                        lo_sent       <= last_byte;
                        if (!last_byte) state <= PAY_HI;
                    end
                end
                GAP: begin
                    if (gap_cnt >= GAP_LAST) state <= IDLE;
                    else gap_cnt <= gap_cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qam16_frame_scheduler.sv
// tb_qam16_frame_scheduler: table-driven frame vectors with a symbol scoreboard,
// plus hand sequences for err_clear, enable gating, mid-frame reset and counter wrap.
module tb_qam16_frame_scheduler;
    logic        aclk = 1'b0;
    logic        reset;
    logic        enable;
    logic        err_clear;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [3:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        length_error;

    int checks = 0;
    int fails = 0;
    logic [3:0] expq[$];
    logic [7:0] src[4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    typedef struct {
        string name;
        bit    toggle;
        int    stall_after;
        int    n_bytes;
        bit    exp_err;
    } vec_t;
    vec_t vecs[4];

    int idx, stall, n_bytes, stall_after;
    bit toggle, acc, hold_v, seen;
    logic [3:0] hold_d;

    qam16_frame_scheduler #(.PAYLOAD_BYTES(4)) dut (
        .aclk(aclk), .reset(reset), .enable(enable), .err_clear(err_clear),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready), .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .busy(busy), .frame_done(frame_done),
        .frame_count(frame_count), .length_error(length_error)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sample();
        @(negedge aclk);
        if (hold_v) begin
            check("hold tvalid", 32'(m_tvalid), 32'd1);
            check("hold tdata", 32'(m_tdata), 32'(hold_d));
        end
        if (stall == 1 || stall == 2) check("stall tvalid low", 32'(m_tvalid), 32'd0);
        if (m_tvalid && m_tready) begin
            if (expq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL extra symbol: got %0h expected none", m_tdata);
            end else check("symbol", 32'(m_tdata), 32'(expq.pop_front()));
        end
        hold_v = m_tvalid && !m_tready;
        hold_d = m_tdata;
        acc = s_tvalid && s_tready;
    endtask

    task automatic drive();
        @(posedge aclk);
        #1;
        if (stall > 0) stall--;
        if (acc) begin
            idx++;
            if (idx == stall_after) stall = 5;
        end
        s_tvalid = (idx < n_bytes) && (stall == 0);
        s_tdata  = src[idx < 4 ? idx : 0];
        s_tlast  = (idx == n_bytes - 1);
        m_tready = toggle ? ~m_tready : 1'b1;
    endtask

    task automatic start_frame(input bit tg, input int sa, input int nb);
        @(posedge aclk);
        #1;
        toggle = tg; stall_after = sa; n_bytes = nb;
        idx = 0; stall = 0; acc = 0; hold_v = 0;
        enable = 1'b1; s_tvalid = 1'b1; s_tdata = src[0]; s_tlast = (nb == 1); m_tready = 1'b1;
        for (int i = 0; i < 8; i++) expq.push_back(i[0] ? 4'hF : 4'h0);
        expq.push_back(4'hD); expq.push_back(4'h3); expq.push_back(4'h9); expq.push_back(4'h1);
        for (int b = 0; b < nb; b++) begin
            expq.push_back(src[b][7:4]);
            expq.push_back(src[b][3:0]);
        end
    endtask

    task automatic finish_frame(input logic [15:0] exp_count, input logic exp_err);
        seen = 0;
        for (int c = 0; c < 300 && !seen; c++) begin
            sample();
            if (frame_done) seen = 1;
            else drive();
        end
        check("frame_done seen", 32'(seen), 32'd1);
        check("all symbols sent", 32'(expq.size()), 32'd0);
        check("frame_count", 32'(frame_count), 32'(exp_count));
        check("length_error", 32'(length_error), 32'(exp_err));
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) @(negedge aclk);
            if (k < 16) check("gap tvalid", 32'(m_tvalid), 32'd0);
            if (k == 1) check("frame_done one cycle", 32'(frame_done), 32'd0);
            if (k == 15) check("busy in gap", 32'(busy), 32'd1);
            if (k == 16) check("idle after gap", 32'(busy), 32'd0);
        end
        expq.delete();
    endtask

    initial begin
        vecs[0] = '{name: "basic",        toggle: 0, stall_after: -1, n_bytes: 4, exp_err: 0};
        vecs[1] = '{name: "backpressure", toggle: 1, stall_after: -1, n_bytes: 4, exp_err: 0};
        vecs[2] = '{name: "starvation",   toggle: 0, stall_after: 2,  n_bytes: 4, exp_err: 0};
        vecs[3] = '{name: "early tlast",  toggle: 0, stall_after: -1, n_bytes: 2, exp_err: 1};
        reset = 1'b1; enable = 1'b0; err_clear = 1'b0;
        s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        idx = 0; stall = 0; n_bytes = 0; stall_after = -1; toggle = 0; acc = 0; hold_v = 0;
        repeat (2) @(negedge aclk);
        check("reset tvalid", 32'(m_tvalid), 32'd0);
        check("reset tdata", 32'(m_tdata), 32'd0);
        check("reset s_tready", 32'(s_tready), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset frame_count", 32'(frame_count), 32'd0);
        check("reset length_error", 32'(length_error), 32'd0);
        @(posedge aclk);
        #1 reset = 1'b0;

        for (int v = 0; v < 4; v++) begin
            start_frame(vecs[v].toggle, vecs[v].stall_after, vecs[v].n_bytes);
            finish_frame(16'(v + 1), vecs[v].exp_err);
        end

        @(posedge aclk);
        #1 err_clear = 1'b1;
        @(posedge aclk);
        #1 err_clear = 1'b0;
        @(negedge aclk);
        check("err_clear", 32'(length_error), 32'd0);

        @(posedge aclk);
        #1 enable = 1'b0; s_tvalid = 1'b1; s_tdata = src[0]; m_tready = 1'b1;
        repeat (6) begin
            @(negedge aclk);
            check("disabled tvalid", 32'(m_tvalid), 32'd0);
            check("disabled s_tready", 32'(s_tready), 32'd0);
            check("disabled busy", 32'(busy), 32'd0);
        end

        start_frame(0, -1, 4);
        for (int c = 0; c < 100 && expq.size() > 5; c++) begin
            sample();
            if (expq.size() > 5) drive();
        end
        check("reached 3rd payload symbol", 32'(expq.size()), 32'd5);
        @(posedge aclk);
        #1 reset = 1'b1;
        #1;
        check("mid reset tvalid", 32'(m_tvalid), 32'd0);
        check("mid reset tdata", 32'(m_tdata), 32'd0);
        check("mid reset s_tready", 32'(s_tready), 32'd0);
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset frame_count", 32'(frame_count), 32'd0);
        expq.delete();
        start_frame(0, -1, 4);
        reset = 1'b0;
        finish_frame(16'd1, 1'b0);

        force dut.frame_count = 16'hFFFF;
        #2 release dut.frame_count;
        #1 check("preload frame_count", 32'(frame_count), 32'hFFFF);
        start_frame(0, -1, 4);
        finish_frame(16'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
